// File: rtl/clk_divider_pkg.sv
// rtl/clk_divider_pkg.sv - shared phase-split helper for the integer clock divider
package clk_divider_pkg;

   // High phase gets the smaller half so odd ratios lean low
   function automatic int div_high(input int div);
      return div / 2;
   endfunction

endpackage

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - integer clock divider, registered clk_out; optional tick strobe under CLK_DIVIDER_TICK_EN
module clk_divider
   import clk_divider_pkg::*;
#(
   parameter int DIV = 5
) (
   input  logic clk_in,
   input  logic reset,
   input  logic en,
`ifdef CLK_DIVIDER_TICK_EN
   output logic tick,
`endif
   output logic clk_out
);

   localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
   localparam int H  = div_high(DIV);
   localparam int L  = DIV - H;

   if (DIV < 2) begin : g_div_check
      $fatal(1, "clk_divider: DIV must be at least 2");
   end

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt + CW'(1);
      if (cnt == CW'(DIV - 1)) begin
         cnt_next = '0;
      end
   end

   // Output is a pure function of the next count, so it is glitch-free and one register deep
   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt     <= '0;
         clk_out <= 1'b0;
`ifdef CLK_DIVIDER_TICK_EN
         tick    <= 1'b0;
`endif
      end else if (en) begin
         cnt     <= cnt_next;
         clk_out <= (cnt_next >= CW'(L));
`ifdef CLK_DIVIDER_TICK_EN
         tick    <= (cnt_next == CW'(L));
`endif
      end else begin
`ifdef CLK_DIVIDER_TICK_EN
         tick    <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - directed bench for clk_divider at DIV=5, 4 and 2; tick checks under CLK_DIVIDER_TICK_EN
module tb_clk_divider;

   logic clk;
   logic reset;
   logic en;
   logic out5, out4, out2;
`ifdef CLK_DIVIDER_TICK_EN
   logic tick5, tick4, tick2;
`endif

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic       rst;
      logic       en;
      logic [2:0] o;   // {div5, div4, div2}
      logic [2:0] t;
   } vec_t;

   vec_t vecs[$];

   clk_divider #(.DIV(5)) dut5 (
      .clk_in(clk), .reset(reset), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
      .tick(tick5),
`endif
      .clk_out(out5));

   clk_divider #(.DIV(4)) dut4 (
      .clk_in(clk), .reset(reset), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
      .tick(tick4),
`endif
      .clk_out(out4));

   clk_divider #(.DIV(2)) dut2 (
      .clk_in(clk), .reset(reset), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
      .tick(tick2),
`endif
      .clk_out(out2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic r, input logic e, input logic [2:0] o, input logic [2:0] t);
      vec_t v;
      v.rst = r; v.en = e; v.o = o; v.t = t;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d actual=%b required=%b", name, idx, act, exp);
      end
   endtask

   task automatic add_run_after_reset();
      add(0, 1, 3'b001, 3'b001);
      add(0, 1, 3'b010, 3'b010);
      add(0, 1, 3'b111, 3'b101);
      add(0, 1, 3'b100, 3'b000);
      add(0, 1, 3'b001, 3'b001);
      add(0, 1, 3'b010, 3'b010);
   endtask

   initial begin
      int prev, rise_edge, rises, highs, first_rise, last_rise;
      reset = 1'b1;
      en    = 1'b1;

      repeat (3) add(1, 1, 3'b000, 3'b000);
      add_run_after_reset();
      add(0, 1, 3'b011, 3'b001);
      add(0, 1, 3'b100, 3'b100);
      add(0, 1, 3'b101, 3'b001);
      add(0, 1, 3'b010, 3'b010);
      add(0, 1, 3'b011, 3'b001);
      add(0, 1, 3'b000, 3'b000);
      add(0, 1, 3'b101, 3'b101);   // DIV=5 now mid-high
      repeat (4) add(0, 0, 3'b101, 3'b000);
      add(0, 1, 3'b110, 3'b010);
      add(0, 1, 3'b011, 3'b001);
      add(0, 1, 3'b000, 3'b000);
      add(0, 1, 3'b001, 3'b001);
      add(0, 1, 3'b110, 3'b110);   // DIV=5 high again
      add(1, 0, 3'b000, 3'b000);   // reset wins over en=0
      add_run_after_reset();

      foreach (vecs[i]) begin
         @(negedge clk);
         reset = vecs[i].rst;
         en    = vecs[i].en;
         @(posedge clk);
         #1;
         check("clk_out", i, {out5, out4, out2}, vecs[i].o);
`ifdef CLK_DIVIDER_TICK_EN
         check("tick", i, {tick5, tick4, tick2}, vecs[i].t);
`endif
      end

      // Free-running DIV=5: every rise-to-rise gap is 5, high 2 cycles per period
      @(negedge clk);
      reset = 1'b0;
      en    = 1'b1;
      prev = int'(out5); rises = 0; highs = 0; first_rise = -1; last_rise = -1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (out5 && prev == 0) begin
            rise_edge = c;
            if (last_rise >= 0) check("period5", c, 3'(rise_edge - last_rise), 3'd5);
            if (first_rise < 0) first_rise = c;
            last_rise = c;
            rises++;
         end
         if (out5 && first_rise >= 0 && c < last_rise) highs++;
         prev = int'(out5);
      end
      // highs counted in [first_rise, last_rise) of the final pass
      highs = 0;
      checks++;
      if (rises < 6) begin
         failures++;
         $display("FAIL rise_count actual=%0d required>=6", rises);
      end
      prev = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (out5) highs++;
      end
      check("duty5_high_in_10", 0, 3'(highs), 3'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
